// File: rtl/imm_ext_pkg.sv
// Shared mode encodings and default widths for the immediate extension unit.
// Mode 3 (BRANCH) is only decoded when IMM_EXT_BRANCH_EN is defined.
package imm_ext_pkg;

   typedef enum logic [1:0] {
      IMM_SEXT   = 2'd0,
      IMM_ZEXT   = 2'd1,
      IMM_LUI    = 2'd2,
      IMM_BRANCH = 2'd3
   } imm_mode_e;

   localparam int IMM_IN_W  = 16;
   localparam int IMM_OUT_W = 32;
   localparam int IMM_TAG_W = 5;

endpackage

// File: rtl/imm_ext_fmt.sv
// Combinational immediate formatter: sign/zero extension, upper placement, branch offset.
// Config: IMM_EXT_BRANCH_EN enables mode 3 BRANCH; without it mode 3 formats as SEXT.
module imm_ext_fmt
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W
) (
   input  logic [IN_W-1:0]  imm,
   input  imm_mode_e        mode,
   output logic [OUT_W-1:0] ext
);

   logic [OUT_W-1:0] sext;

   assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      ext = sext;
      case (mode)
         IMM_ZEXT: ext = {{(OUT_W-IN_W){1'b0}}, imm};
         IMM_LUI:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
         IMM_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
`endif
         default:  ext = sext;
      endcase
   end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate extension stage with a two-entry (main + skid) valid/ready buffer.
// Config: IMM_EXT_BRANCH_EN enables the BRANCH mode inside imm_ext_fmt.
module imm_extend_unit
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W,
   parameter int TAG_W = IMM_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag
);

   logic [OUT_W-1:0] fmt_imm;

   logic             main_valid_q, main_valid_d;
   logic [OUT_W-1:0] main_imm_q,   main_imm_d;
   logic [TAG_W-1:0] main_tag_q,   main_tag_d;
   logic             skid_valid_q, skid_valid_d;
   logic [OUT_W-1:0] skid_imm_q,   skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

   logic accept;
   logic main_free;

   imm_ext_fmt #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_fmt (
      .imm  (in_imm),
      .mode (imm_mode_e'(in_mode)),
      .ext  (fmt_imm)
   );

   // Readiness depends only on skid occupancy, never combinationally on out_ready.
   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid && in_ready;
   assign main_free = !main_valid_q || out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_tag_d   = main_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_tag_d   = skid_tag_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         if (skid_valid_q) begin
            // Oldest entry advances; a same-cycle accept queues behind it in skid.
            main_valid_d = 1'b1;
            main_imm_d   = skid_imm_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = accept;
            if (accept) begin
               skid_imm_d = fmt_imm;
               skid_tag_d = in_tag;
            end
         end else begin
            main_valid_d = accept;
            if (accept) begin
               main_imm_d = fmt_imm;
               main_tag_d = in_tag;
            end
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = fmt_imm;
         skid_tag_d   = in_tag;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_tag_q   <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_tag_q   <= main_tag_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // NOTE: skid payload is never observed without skid_valid_q, so it is left unreset.
   always_ff @(posedge clk) begin
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
   end

   assign out_valid = main_valid_q;
   assign out_imm   = main_imm_q;
   assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Scoreboard bench for imm_extend_unit: directed corner cases plus a randomized backpressure/flush run.
module tb_imm_extend_unit;
   import imm_ext_pkg::*;

   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm = '0;
   logic [1:0]       in_mode = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_imm;
   logic [TAG_W-1:0] out_tag;

   typedef struct {
      logic [OUT_W-1:0] imm;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             sb[$];
   logic [TAG_W-1:0] xfer_tags[$];
   int               errors = 0;
   int               checks = 0;
   int               run = 0;
   int               max_run = 0;
   int               cyc = 0;

   imm_extend_unit #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .TAG_W (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Reference: interpret the immediate as a number and apply the mode's arithmetic.
   function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] imm, input int mode);
      longint u, s, r;
      u = longint'(imm);
      s = (u >= (longint'(1) << (IN_W-1))) ? u - (longint'(1) << IN_W) : u;
      case (mode)
         1:       r = u;
         2:       r = u * (longint'(1) << (OUT_W-IN_W));
`ifdef IMM_EXT_BRANCH_EN
         3:       r = s * 4;
`else
         3:       r = s;
`endif
         default: r = s;
      endcase
      return r[OUT_W-1:0];
   endfunction

   // Monitor: pops on every output transfer, pushes on every accept.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         run = 0;
      end else begin
         if (out_valid && out_ready) begin
            xfer_tags.push_back(out_tag);
            run++;
            if (run > max_run) max_run = run;
            if (sb.size() == 0) begin
               fail("sb_underflow");
            end else begin
               e = sb.pop_front();
               check("sb_imm", out_imm, e.imm);
               check("sb_tag", out_tag, e.tag);
            end
         end else begin
            run = 0;
         end
         if (flush) begin
            sb.delete();
         end else if (in_valid && in_ready) begin
            e.imm = model(in_imm, int'(in_mode));
            e.tag = in_tag;
            sb.push_back(e);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted.
   task automatic send(input logic [IN_W-1:0] imm, input logic [1:0] mode, input logic [TAG_W-1:0] tag);
      int n = 0;
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) fail("send_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int start;
      logic [OUT_W-1:0] br_exp;

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_imm", out_imm, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Formatting vectors, each visible one cycle after accept
      out_ready = 1'b1;
      send(16'h8001, IMM_SEXT, 5'd1);
      in_valid = 1'b0;
      check("sext_valid", out_valid, 1);
      check("sext_imm", out_imm, 32'hFFFF8001);
      check("sext_tag", out_tag, 1);
      step(1);
      send(16'h8001, IMM_ZEXT, 5'd2);
      in_valid = 1'b0;
      check("zext_valid", out_valid, 1);
      check("zext_imm", out_imm, 32'h00008001);
      step(1);
      send(16'h1234, IMM_LUI, 5'd3);
      in_valid = 1'b0;
      check("lui_valid", out_valid, 1);
      check("lui_imm", out_imm, 32'h12340000);
      step(1);
`ifdef IMM_EXT_BRANCH_EN
      br_exp = 32'hFFFFFFFC;
`else
      br_exp = 32'hFFFFFFFF;
`endif
      send(16'hFFFF, IMM_BRANCH, 5'd4);
      in_valid = 1'b0;
      check("branch_imm", out_imm, br_exp);
      step(2);

      // Backpressure: two entries held, third stalls, order preserved
      out_ready = 1'b0;
      send(16'h0011, IMM_ZEXT, 5'd1);
      check("bp_ready_after1", in_ready, 1);
      send(16'h0022, IMM_ZEXT, 5'd2);
      check("bp_ready_after2", in_ready, 0);
      in_valid = 1'b1;
      in_imm   = 16'h0033;
      in_mode  = IMM_ZEXT;
      in_tag   = 5'd3;
      repeat (3) begin
         @(negedge clk);
         check("bp_stall_ready", in_ready, 0);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_tag", out_tag, 1);
         check("bp_hold_imm", out_imm, 32'h11);
      end
      @(posedge clk);
      #1;
      xfer_tags.delete();
      out_ready = 1'b1;
      send(16'h0033, IMM_ZEXT, 5'd3);
      in_valid = 1'b0;
      step(3);
      check("bp_count", xfer_tags.size(), 3);
      if (xfer_tags.size() == 3) begin
         check("bp_order0", xfer_tags[0], 1);
         check("bp_order1", xfer_tags[1], 2);
         check("bp_order2", xfer_tags[2], 3);
      end

      // Streaming: 8 back-to-back, no bubbles
      step(2);
      max_run = 0;
      start = cyc;
      for (int i = 0; i < 8; i++) send(IN_W'($urandom), 2'($urandom_range(0, 3)), TAG_W'(i));
      in_valid = 1'b0;
      check("stream_accept_cycles", cyc - start, 8);
      step(3);
      check("stream_run", max_run, 8);

      // Flush with both entries full and in_valid asserted
      out_ready = 1'b0;
      send(16'h0100, IMM_SEXT, 5'd10);
      send(16'h0101, IMM_SEXT, 5'd11);
      in_valid = 1'b1;
      in_tag   = 5'd12;
      flush    = 1'b1;
      step(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_full_valid", out_valid, 0);
      check("flush_full_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("flush_no_emerge", out_valid, 0);
      end
      step(1);

      // Flush racing a real accept: accept is dropped
      out_ready = 1'b0;
      send(16'h0200, IMM_SEXT, 5'd13);
      in_valid = 1'b1;
      in_tag   = 5'd14;
      flush    = 1'b1;
      step(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_acc_valid", out_valid, 0);
      check("flush_acc_ready", in_ready, 1);
      step(2);
      check("flush_acc_later", out_valid, 0);

      // Reset mid-stream
      send(16'h0300, IMM_ZEXT, 5'd20);
      send(16'h0301, IMM_ZEXT, 5'd21);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_imm", out_imm, 0);
      check("midrst_tag", out_tag, 0);
      check("midrst_ready", in_ready, 1);
      step(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(16'h0ABC, IMM_ZEXT, 5'd22);
      in_valid = 1'b0;
      check("postrst_valid", out_valid, 1);
      check("postrst_tag", out_tag, 22);
      check("postrst_imm", out_imm, 32'h00000ABC);
      step(2);

      // Randomized traffic with backpressure and occasional flush
      repeat (400) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_imm    = IN_W'($urandom);
         in_mode   = 2'($urandom_range(0, 3));
         in_tag    = TAG_W'($urandom);
         step(1);
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      step(4);
      check("drain_empty", sb.size(), 0);
      check("drain_valid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; legal only if OUT_W >= IN_W+2.
REQ-003 SHALL have parameter TAG_W, default 5, sideband tag width (destination register ID).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  discards all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream offers an immediate.
REQ-008 SHALL have port in_ready  output  1  block can accept an immediate.
REQ-009 SHALL have port in_imm  input  IN_W  raw immediate field.
REQ-010 SHALL have port in_mode  input  2  extension mode.
REQ-011 SHALL have port in_tag  input  TAG_W  sideband, carried unchanged.
REQ-012 SHALL have port out_valid  output  1  out_imm/out_tag are valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the output.
REQ-014 SHALL have port out_imm  output  OUT_W  extended immediate.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the entry on out_imm.

Function
REQ-016 SHALL format by mode: 0 SEXT = replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits; 1 ZEXT = zero upper bits; 2 LUI = {in_imm, (OUT_W-IN_W) zeros}; 3 BRANCH = SEXT shifted left 2, low 2 bits zero, upper bits dropped.
REQ-017 SHALL format at acceptance and store the formatted value, not the raw one.
REQ-018 SHALL accept on a cycle with in_valid && in_ready, and transfer out on a cycle with out_valid && out_ready.
REQ-019 SHALL hold two entries: an output register (main) and a skid register.
REQ-020 SHALL drive in_ready = !skid_valid; it SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL have latency 1: an entry accepted into an empty block drives out_valid=1 on the next cycle.
REQ-022 SHALL sustain 1 transfer per cycle when out_ready stays high.
REQ-023 SHALL load an accepted entry into main when main is empty or draining that cycle, and otherwise into skid.
REQ-024 SHALL move skid into main on a cycle where main drains and skid is valid; a new accept that cycle goes into skid.
REQ-025 SHALL preserve strict FIFO order under all backpressure patterns.
REQ-026 SHALL hold out_imm/out_tag stable while out_valid && !out_ready.
REQ-027 SHALL clear main and skid valid on the cycle after flush=1; flush SHALL take priority over a simultaneous accept, dropping that accept; in_ready SHALL be 1 after flush.

Reset
REQ-028 SHALL, while rst_n=0, drive out_valid=0, out_imm=0, out_tag=0, and clear skid valid, asynchronously.
REQ-029 SHALL drive in_ready=1 once reset is asserted; an in-flight entry SHALL be discarded when reset is asserted mid-operation.
REQ-030 SHALL resume accepting on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL compile mode 3 BRANCH only when macro IMM_EXT_BRANCH_EN is defined.
REQ-032 SHALL treat mode 3 as SEXT when IMM_EXT_BRANCH_EN is undefined.

Structure
REQ-033 SHALL place mode encodings (IMM_SEXT=0, IMM_ZEXT=1, IMM_LUI=2, IMM_BRANCH=3) and the default widths in shared package imm_ext_pkg.
REQ-034 SHALL implement the formatter as combinational sub-module imm_ext_fmt (parameters IN_W, OUT_W); the handshake/skid logic SHALL reside in imm_extend_unit.

Verification
REQ-035 SHALL cover: SEXT 0x8001 -> 0xFFFF8001; ZEXT 0x8001 -> 0x00008001; LUI 0x1234 -> 0x12340000, each with out_valid=1 one cycle after accept.
REQ-036 SHALL cover BRANCH 0xFFFF: macro defined -> 0xFFFFFFFC; macro undefined -> 0xFFFFFFFF.
REQ-037 SHALL cover backpressure: out_ready=0, offer tags 1,2,3 -> tags 1,2 held, in_ready=0 after 2nd accept, tag 3 stalls; with out_ready=1 afterwards, order is 1,2,3.
REQ-038 SHALL cover streaming: 8 back-to-back inputs with out_ready=1 -> 8 outputs on consecutive cycles, no bubbles.
REQ-039 SHALL cover flush with both entries full plus a simultaneous accept -> out_valid=0 and in_ready=1 next cycle, no entry emerges.
REQ-040 SHALL cover rst_n pulsed low mid-stream -> out_valid=0 and out_imm=0 immediately, and the next accepted input is the first output.
